// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, reset PC and the fetch buffer entry.
package core_pkg;

    localparam int unsigned Data_width = 32;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [Data_width-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [Data_width-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, branch resolve and decode handoff.
interface fetch_unit_if #(
    parameter int unsigned Data_width = core_pkg::Data_width
) ();

    logic                        imem_req_valid;
    logic [Data_width-1:0]       imem_req_addr;
    logic                        imem_req_ready;
    logic                        imem_resp_valid;
    logic [core_pkg::INSTR_W-1:0] imem_resp_data;
    logic                        branch_en;
    logic                        eq;
    logic [Data_width-1:0]       branch_target;
    logic                        instr_valid;
    logic [core_pkg::INSTR_W-1:0] instr;
    logic [Data_width-1:0]       instr_pc;
    logic                        instr_ready;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  branch_en, eq, branch_target,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output branch_en, eq, branch_target,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with flush; flush discards contents and any same-cycle push.
module fetch_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_q, wr_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // Storage write; contents need no reset since the count gates validity
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-flight PC queue,
// instruction buffer, and taken-branch redirect with wrong-path discard.
module fetch_unit #(
    parameter int unsigned            Data_width = core_pkg::Data_width,
    parameter logic [Data_width-1:0]  RESET_PC   = core_pkg::RESET_PC,
    parameter int unsigned            DEPTH      = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [core_pkg::INSTR_W-1:0] instr;
        logic [Data_width-1:0]        pc;
    } entry_t;

    logic [Data_width-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]       drop_q, drop_d;
    logic [CntW-1:0]       outstanding, count;
    logic                  credit_ok, req_fire, resp, taken, consume, dropping, buf_push;
    logic                  head_valid;
    logic [Data_width-1:0] resp_pc;
    entry_t                buf_wdata, buf_head;

    // Credit counts both buffered and in-flight entries so the buffer can never overflow
    assign credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < (CntW + 1)'(DEPTH);
    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign resp       = bus.imem_resp_valid;
    assign taken      = bus.branch_en && bus.eq;
    assign head_valid = (count != '0);
    assign consume    = head_valid && bus.instr_ready;
    assign dropping   = (drop_q != '0);
    assign buf_push   = resp && !dropping && !taken;
    assign buf_wdata  = '{instr: bus.imem_resp_data, pc: resp_pc};

    // Next PC and drop count; a redirect owns every response not yet returned
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (taken) begin
            fetch_pc_d = {bus.branch_target[Data_width-1:2], 2'b00};
            drop_d     = outstanding + CntW'(req_fire) - CntW'(resp);
        end else begin
            if (req_fire)         fetch_pc_d = fetch_pc_q + Data_width'(4);
            if (resp && dropping) drop_d     = drop_q - CntW'(1);
        end
    end

    // PC and drop-count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    // PC of each accepted request; its occupancy is the outstanding count
    fetch_fifo #(
        .Width (Data_width),
        .Depth (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_fire),
        .pop   (resp),
        .wdata (fetch_pc_q),
        .rdata (resp_pc),
        .count (outstanding)
    );

    // Decoded-ready buffer; pop and flush can coincide, both empty the head
    fetch_fifo #(
        .Width ($bits(entry_t)),
        .Depth (DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (taken),
        .push  (buf_push),
        .pop   (consume),
        .wdata (buf_wdata),
        .rdata (buf_head),
        .count (count)
    );

    assign bus.imem_req_valid = !rst && credit_ok;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? buf_head.instr : '0;
    assign bus.instr_pc       = head_valid ? buf_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, transaction scoreboard, directed scenarios.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int unsigned DEPTH = 3;

    logic clk;
    logic rst;
    logic mem_ready;
    logic mem_hold;

    fetch_unit_if #(.Data_width(Data_width)) bus ();

    fetch_unit #(
        .Data_width (Data_width),
        .RESET_PC   (RESET_PC),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_req_ready = mem_ready;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[23:0], a[31:24]} ^ 32'hA5C3_0F96;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory: in-order, one response per accepted request, earliest the next cycle
    logic [31:0] mq[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            bus.imem_resp_valid <= 1'b0;
            bus.imem_resp_data  <= '0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) mq.push_back(bus.imem_req_addr);
            if (!mem_hold && mq.size() != 0) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_resp_data  <= mem_data(mq.pop_front());
            end else begin
                bus.imem_resp_valid <= 1'b0;
            end
        end
    end

    // Reference model and scoreboard, sampled mid-cycle ahead of the next rising edge
    typedef struct {
        logic [31:0] addr;
        bit          killed;
    } flight_t;

    flight_t      inflight[$];
    fetch_entry_t sb[$];
    logic [31:0]  model_pc = RESET_PC;
    int           fire_cnt = 0;
    int           deliv_cnt = 0;
    logic [31:0]  last_fire_addr = '0;
    logic [31:0]  last_deliv_pc = '0;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                inflight.delete();
                sb.delete();
                model_pc = RESET_PC;
            end else begin
                logic         fire, resp, cons, tkn;
                fetch_entry_t e;
                flight_t      f;
                fire = bus.imem_req_valid && bus.imem_req_ready;
                resp = bus.imem_resp_valid;
                cons = bus.instr_valid && bus.instr_ready;
                tkn  = bus.branch_en && bus.eq;
                check_eq("req_valid", bus.imem_req_valid, (sb.size() + inflight.size()) < DEPTH);
                check_eq("instr_valid", bus.instr_valid, sb.size() != 0);
                if (cons) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("instr", bus.instr, e.instr);
                        check_eq("instr_pc", bus.instr_pc, e.pc);
                    end
                    deliv_cnt++;
                    last_deliv_pc = bus.instr_pc;
                end
                if (tkn) begin
                    sb.delete();
                    foreach (inflight[i]) inflight[i].killed = 1'b1;
                end
                if (resp) begin
                    assert (inflight.size() != 0) else $error("response with nothing outstanding");
                    if (inflight.size() != 0) begin
                        f = inflight.pop_front();
                        if (!f.killed) sb.push_back('{instr: mem_data(f.addr), pc: f.addr});
                    end
                end
                if (fire) begin
                    check_eq("req_addr", bus.imem_req_addr, model_pc);
                    inflight.push_back('{addr: model_pc, killed: tkn});
                    model_pc       = model_pc + 32'd4;
                    fire_cnt++;
                    last_fire_addr = bus.imem_req_addr;
                end
                if (tkn) model_pc = {bus.branch_target[31:2], 2'b00};
            end
        end
    end

    task automatic wait_fire(input int base, input string tag);
        for (int i = 0; i < 50; i++) begin
            if (fire_cnt > base) return;
            @(negedge clk);
        end
        check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_deliv(input int base, input string tag);
        for (int i = 0; i < 50; i++) begin
            if (deliv_cnt > base) return;
            @(negedge clk);
        end
        check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, bus.imem_req_valid, 0);
        check_eq({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
        check_eq({tag, "_instr_valid"}, bus.instr_valid, 0);
        check_eq({tag, "_instr"}, bus.instr, 0);
        check_eq({tag, "_instr_pc"}, bus.instr_pc, 0);
    endtask

    initial begin
        int          d0, f0, lat, d;
        logic [31:0] p0;
        bit          stable;
        rst               = 1'b1;
        mem_ready         = 1'b1;
        mem_hold          = 1'b0;
        bus.instr_ready   = 1'b1;
        bus.branch_en     = 1'b0;
        bus.eq            = 1'b0;
        bus.branch_target = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("rst");

        // Release and sustained fetch
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("first_req_valid", bus.imem_req_valid, 1);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (bus.instr_valid) begin
                lat = n;
                break;
            end
        end
        check_eq("first_valid_latency", lat, 2);
        @(negedge clk);
        d0 = deliv_cnt;
        repeat (30) @(negedge clk);
        check_eq("throughput", (deliv_cnt - d0) >= 28, 1);

        // Branch not taken: stream continues at +4
        bus.branch_en = 1'b1;
        bus.eq = 1'b0;
        bus.branch_target = 32'h500;
        p0 = last_deliv_pc;
        d0 = deliv_cnt;
        @(negedge clk);
        bus.branch_en = 1'b0;
        repeat (5) @(negedge clk);
        d = deliv_cnt - d0;
        check_eq("not_taken_seq", last_deliv_pc, p0 + 32'(4 * d));

        // Redirect coinciding with response, request accept and consume
        check_eq("sim_cond", {bus.imem_req_valid && bus.imem_req_ready, bus.imem_resp_valid,
                              bus.instr_valid && bus.instr_ready}, 3'b111);
        bus.branch_en = 1'b1;
        bus.eq = 1'b1;
        bus.branch_target = 32'h200;
        d0 = deliv_cnt;
        @(negedge clk);
        bus.branch_en = 1'b0;
        bus.eq = 1'b0;
        check_eq("sim_consumed", deliv_cnt - d0, 1);
        wait_deliv(d0 + 1, "sim_deliv");
        check_eq("sim_first_pc", last_deliv_pc, 32'h200);

        // Backpressure from reset
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        f0 = fire_cnt;
        rst = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr_valid && (bus.instr_pc !== 32'h0 || bus.instr !== mem_data(32'h0)))
                stable = 1'b0;
        end
        check_eq("bp_requests", fire_cnt - f0, DEPTH);
        check_eq("bp_req_valid", bus.imem_req_valid, 0);
        check_eq("bp_head_pc", bus.instr_pc, 32'h0);
        check_eq("bp_head_instr", bus.instr, mem_data(32'h0));
        check_eq("bp_stable", stable, 1);
        bus.instr_ready = 1'b1;
        d0 = deliv_cnt;
        repeat (6) @(negedge clk);
        check_eq("bp_drain", (deliv_cnt - d0) >= 3, 1);

        // Redirect with two requests outstanding
        rst = 1'b1;
        mem_hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        f0 = fire_cnt;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        check_eq("rd_outstanding", fire_cnt - f0, 2);
        bus.branch_en = 1'b1;
        bus.eq = 1'b1;
        bus.branch_target = 32'h103;
        @(negedge clk);
        bus.branch_en = 1'b0;
        bus.eq = 1'b0;
        mem_ready = 1'b1;
        mem_hold = 1'b0;
        f0 = fire_cnt;
        d0 = deliv_cnt;
        wait_fire(f0, "rd_fire");
        check_eq("rd_target_addr", last_fire_addr, 32'h100);
        wait_deliv(d0, "rd_deliv");
        check_eq("rd_first_pc", last_deliv_pc, 32'h100);

        // Async reset mid-stream with responses held back
        repeat (8) @(negedge clk);
        mem_hold = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        mem_hold = 1'b0;
        @(negedge clk);
        f0 = fire_cnt;
        d0 = deliv_cnt;
        rst = 1'b0;
        wait_fire(f0, "ar_fire");
        check_eq("ar_restart_addr", last_fire_addr, RESET_PC);
        wait_deliv(d0, "ar_deliv");
        check_eq("ar_first_pc", last_deliv_pc, RESET_PC);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
